// File: rtl/rf_pkg.sv
// Shared constants for the multi-port integer register file and its scoreboard.
package rf_pkg;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_DEPTH = 32;
    localparam int REG_ADDR_W    = $clog2(DEFAULT_DEPTH);
    localparam int ZERO_REG      = 0;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set on issue, cleared on writeback, wiped on flush.
// Also performs the rd_busy lookup for every read port.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int REG_FILE_DEPTH = DEFAULT_DEPTH,
    parameter int ADDR_W         = $clog2(REG_FILE_DEPTH),
    parameter int NUM_RD         = 2,
    parameter int NUM_WR         = 1,
    parameter int BYPASS         = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic [NUM_WR-1:0]        wr_valid,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy
);

    logic [REG_FILE_DEPTH-1:0] pending;
    logic [REG_FILE_DEPTH-1:0] set_vec;
    logic [REG_FILE_DEPTH-1:0] clr_vec;

    // wr_valid already excludes x0 and out-of-range targets.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_en && issue_addr != ADDR_W'(ZERO_REG) && int'(issue_addr) < REG_FILE_DEPTH)
            set_vec[issue_addr] = 1'b1;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_valid[k])
                clr_vec[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b1;
        end
    end

    // Set is OR-ed in after the clear so a new producer supersedes the retiring one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pending <= '0;
        else if (flush)
            pending <= '0;
        else
            pending <= (pending & ~clr_vec) | set_vec;
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (int'(rd_addr[i*ADDR_W +: ADDR_W]) < REG_FILE_DEPTH)
                rd_busy[i] = pending[rd_addr[i*ADDR_W +: ADDR_W]]
                             && !(BYPASS != 0 && clr_vec[rd_addr[i*ADDR_W +: ADDR_W]]);
        end
    end

endmodule : rf_scoreboard

// File: rtl/register_file_mp.sv
// Multi-port integer register file: NUM_RD combinational reads, NUM_WR synchronous
// writes, optional same-cycle write-to-read bypass, and a RAW-hazard scoreboard.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN              = DEFAULT_XLEN,
    parameter int REG_FILE_DEPTH    = DEFAULT_DEPTH,
    parameter int REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH),
    parameter int NUM_RD            = 2,
    parameter int NUM_WR            = 1,
    parameter int BYPASS            = 1
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_WR-1:0]                   wr_en,
    input  logic [NUM_WR*REG_FILE_ADDR_LEN-1:0] wr_addr,
    input  logic [NUM_WR*XLEN-1:0]              wr_data,
    input  logic [NUM_RD*REG_FILE_ADDR_LEN-1:0] rd_addr,
    output logic [NUM_RD*XLEN-1:0]              rd_data,
    output logic [NUM_RD-1:0]                   rd_busy,
    input  logic                                issue_en,
    input  logic [REG_FILE_ADDR_LEN-1:0]        issue_addr,
    input  logic                                flush
);

    localparam int AW = REG_FILE_ADDR_LEN;

    logic [XLEN-1:0]   regs [REG_FILE_DEPTH];
    logic [NUM_WR-1:0] wr_valid;

    always_comb begin
        wr_valid = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            wr_valid[k] = wr_en[k]
                          && wr_addr[k*AW +: AW] != AW'(ZERO_REG)
                          && int'(wr_addr[k*AW +: AW]) < REG_FILE_DEPTH;
        end
    end

    // NOTE: storage is reset because software may read any register before writing it,
    // so it maps to flops rather than a RAM macro. Ports are visited in ascending order
    // and the last non-blocking assignment to an element wins, giving the higher port priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < REG_FILE_DEPTH; r++)
                regs[r] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_valid[k])
                    regs[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
            end
        end
    end

    // Bypass is suppressed while in reset so every read returns 0 until release.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_addr[i*AW +: AW] != AW'(ZERO_REG) && int'(rd_addr[i*AW +: AW]) < REG_FILE_DEPTH)
                rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
            if (BYPASS != 0 && reset_n) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_valid[k] && wr_addr[k*AW +: AW] == rd_addr[i*AW +: AW])
                        rd_data[i*XLEN +: XLEN] = wr_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    rf_scoreboard #(
        .REG_FILE_DEPTH (REG_FILE_DEPTH),
        .ADDR_W         (AW),
        .NUM_RD         (NUM_RD),
        .NUM_WR         (NUM_WR),
        .BYPASS         (BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy)
    );

endmodule : register_file_mp

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a bypassing and a non-bypassing instance share stimulus
// and are compared against an array-based model of the architectural register rules.
module tb_register_file_mp;

    localparam int XL = 32;
    localparam int D  = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NW-1:0]    wr_en = '0;
    logic [NW*AW-1:0] wr_addr = '0;
    logic [NW*XL-1:0] wr_data = '0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic             issue_en = 1'b0;
    logic [AW-1:0]    issue_addr = '0;
    logic             flush = 1'b0;
    logic [NR*XL-1:0] rd_data_b;
    logic [NR*XL-1:0] rd_data_n;
    logic [NR-1:0]    rd_busy_b;
    logic [NR-1:0]    rd_busy_n;

    int total = 0;
    int bad   = 0;

    logic [XL-1:0] m_regs [D];
    bit            m_pend [D];

    always #5 clk = ~clk;

    register_file_mp #(.XLEN(XL), .REG_FILE_DEPTH(D), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush));

    register_file_mp #(.XLEN(XL), .REG_FILE_DEPTH(D), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) dut_n (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush));

    function automatic logic [AW-1:0] wa(int k);
        return wr_addr[k*AW +: AW];
    endfunction

    function automatic logic [XL-1:0] wd(int k);
        return wr_data[k*XL +: XL];
    endfunction

    function automatic logic [AW-1:0] ra(int i);
        return rd_addr[i*AW +: AW];
    endfunction

    function automatic logic [XL-1:0] rdb(int i);
        return rd_data_b[i*XL +: XL];
    endfunction

    function automatic logic [XL-1:0] rdn(int i);
        return rd_data_n[i*XL +: XL];
    endfunction

    function automatic bit write_hit(logic [AW-1:0] a);
        for (int k = 0; k < NW; k++)
            if (wr_en[k] && wa(k) == a && a != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [XL-1:0] exp_data(logic [AW-1:0] a, bit byp);
        logic [XL-1:0] v;
        if (a == 0 || !reset_n) return '0;
        v = m_regs[a];
        if (byp)
            for (int k = 0; k < NW; k++)
                if (wr_en[k] && wa(k) == a) v = wd(k);
        return v;
    endfunction

    function automatic bit exp_busy(logic [AW-1:0] a, bit byp);
        if (a == 0 || !reset_n) return 1'b0;
        if (byp && write_hit(a)) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < D; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int r = 1; r < D; r++) begin
            if (flush)                                  m_pend[r] = 1'b0;
            else if (issue_en && int'(issue_addr) == r) m_pend[r] = 1'b1;
            else if (write_hit(AW'(r)))                 m_pend[r] = 1'b0;
        end
        for (int k = 0; k < NW; k++)
            if (wr_en[k] && wa(k) != 0) m_regs[wa(k)] = wd(k);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        issue_en = 1'b0;
        issue_addr = '0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        reset_n = 1'b0;
        idle();
        wr_en = 2'b11;
        wr_addr = {5'd5, 5'd5};
        wr_data = {$urandom, $urandom};
        rd_addr = {5'd5, 5'd5};
        tick();
        tick();
        #2;
        for (int i = 0; i < NR; i++) begin
            total += 4;
            if (rdb(i) !== '0) begin bad++; $display("FAIL reset.data_b[%0d] got=%h exp=0", i, rdb(i)); end
            if (rdn(i) !== '0) begin bad++; $display("FAIL reset.data_n[%0d] got=%h exp=0", i, rdn(i)); end
            if (rd_busy_b[i] !== 1'b0) begin bad++; $display("FAIL reset.busy_b[%0d] got=%b exp=0", i, rd_busy_b[i]); end
            if (rd_busy_n[i] !== 1'b0) begin bad++; $display("FAIL reset.busy_n[%0d] got=%b exp=0", i, rd_busy_n[i]); end
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        #2;
        total++;
        if (rdn(0) !== '0) begin bad++; $display("FAIL reset.release got=%h exp=0", rdn(0)); end
        tick();
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd5};
        wr_data = {32'h0, 32'hDEADBEEF};
        tick();
        idle();
        #2;
        total++;
        if (rdn(0) !== 32'hDEADBEEF) begin bad++; $display("FAIL reset.pre_write got=%h exp=deadbeef", rdn(0)); end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        total += 2;
        if (rdn(0) !== '0) begin bad++; $display("FAIL reset.async_n got=%h exp=0", rdn(0)); end
        if (rdb(0) !== '0) begin bad++; $display("FAIL reset.async_b got=%h exp=0", rdb(0)); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        idle();
        rd_addr = {5'd0, 5'd3};
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd3};
        wr_data = {32'h0, 32'h12345678};
        #2;
        total += 2;
        if (rdn(0) !== exp_data(5'd3, 1'b0)) begin bad++; $display("FAIL latency.old_n got=%h exp=%h", rdn(0), exp_data(5'd3, 1'b0)); end
        if (rdb(0) !== 32'h12345678) begin bad++; $display("FAIL latency.bypass got=%h exp=12345678", rdb(0)); end
        tick();
        idle();
        #2;
        total++;
        if (rdn(0) !== 32'h12345678) begin bad++; $display("FAIL latency.next_n got=%h exp=12345678", rdn(0)); end
    endtask

    task automatic test_x0();
        idle();
        rd_addr = '0;
        wr_en = 2'b11;
        wr_addr = '0;
        wr_data = '1;
        issue_en = 1'b1;
        issue_addr = '0;
        for (int pass = 0; pass < 2; pass++) begin
            #2;
            for (int i = 0; i < NR; i++) begin
                total += 4;
                if (rdb(i) !== '0) begin bad++; $display("FAIL x0.data_b[%0d] pass%0d got=%h exp=0", i, pass, rdb(i)); end
                if (rdn(i) !== '0) begin bad++; $display("FAIL x0.data_n[%0d] pass%0d got=%h exp=0", i, pass, rdn(i)); end
                if (rd_busy_b[i] !== 1'b0) begin bad++; $display("FAIL x0.busy_b[%0d] pass%0d got=%b exp=0", i, pass, rd_busy_b[i]); end
                if (rd_busy_n[i] !== 1'b0) begin bad++; $display("FAIL x0.busy_n[%0d] pass%0d got=%b exp=0", i, pass, rd_busy_n[i]); end
            end
            tick();
            idle();
        end
    endtask

    task automatic test_conflict();
        idle();
        rd_addr = {5'd0, 5'd7};
        wr_en = 2'b11;
        wr_addr = {5'd7, 5'd7};
        wr_data = {32'h2, 32'h1};
        #2;
        total++;
        if (rdb(0) !== 32'h2) begin bad++; $display("FAIL conflict.bypass got=%h exp=2", rdb(0)); end
        tick();
        idle();
        #2;
        total += 2;
        if (rdb(0) !== 32'h2) begin bad++; $display("FAIL conflict.stored_b got=%h exp=2", rdb(0)); end
        if (rdn(0) !== 32'h2) begin bad++; $display("FAIL conflict.stored_n got=%h exp=2", rdn(0)); end
    endtask

    task automatic test_scoreboard();
        idle();
        rd_addr = {5'd0, 5'd9};
        issue_en = 1'b1;
        issue_addr = 5'd9;
        #2;
        total++;
        if (rd_busy_n[0] !== 1'b0) begin bad++; $display("FAIL sb.before_issue got=%b exp=0", rd_busy_n[0]); end
        tick();
        idle();
        #2;
        total += 2;
        if (rd_busy_b[0] !== 1'b1) begin bad++; $display("FAIL sb.issued_b got=%b exp=1", rd_busy_b[0]); end
        if (rd_busy_n[0] !== 1'b1) begin bad++; $display("FAIL sb.issued_n got=%b exp=1", rd_busy_n[0]); end
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd9};
        wr_data = {32'h0, 32'hA5};
        #2;
        total += 3;
        if (rd_busy_b[0] !== 1'b0) begin bad++; $display("FAIL sb.wb_busy_b got=%b exp=0", rd_busy_b[0]); end
        if (rdb(0) !== 32'hA5) begin bad++; $display("FAIL sb.wb_data_b got=%h exp=a5", rdb(0)); end
        if (rd_busy_n[0] !== 1'b1) begin bad++; $display("FAIL sb.wb_busy_n got=%b exp=1", rd_busy_n[0]); end
        tick();
        idle();
        #2;
        total += 2;
        if (rd_busy_b[0] !== 1'b0) begin bad++; $display("FAIL sb.retired_b got=%b exp=0", rd_busy_b[0]); end
        if (rd_busy_n[0] !== 1'b0) begin bad++; $display("FAIL sb.retired_n got=%b exp=0", rd_busy_n[0]); end
        issue_en = 1'b1;
        issue_addr = 5'd9;
        wr_en = 2'b10;
        wr_addr = {5'd9, 5'd0};
        wr_data = {32'h5A, 32'h0};
        tick();
        idle();
        #2;
        total += 2;
        if (rd_busy_b[0] !== 1'b1) begin bad++; $display("FAIL sb.set_wins_b got=%b exp=1", rd_busy_b[0]); end
        if (rd_busy_n[0] !== 1'b1) begin bad++; $display("FAIL sb.set_wins_n got=%b exp=1", rd_busy_n[0]); end
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd9};
        tick();
        idle();
    endtask

    task automatic test_flush();
        idle();
        issue_en = 1'b1;
        issue_addr = 5'd4;
        tick();
        issue_addr = 5'd6;
        tick();
        idle();
        rd_addr = {5'd6, 5'd4};
        #2;
        total += 2;
        if (rd_busy_n !== 2'b11) begin bad++; $display("FAIL flush.pre got=%b exp=11", rd_busy_n); end
        if (rd_busy_b !== 2'b11) begin bad++; $display("FAIL flush.pre_b got=%b exp=11", rd_busy_b); end
        flush = 1'b1;
        issue_en = 1'b1;
        issue_addr = 5'd8;
        tick();
        idle();
        #2;
        total += 2;
        if (rd_busy_n !== 2'b00) begin bad++; $display("FAIL flush.x4_x6_n got=%b exp=00", rd_busy_n); end
        if (rd_busy_b !== 2'b00) begin bad++; $display("FAIL flush.x4_x6_b got=%b exp=00", rd_busy_b); end
        rd_addr = {5'd0, 5'd8};
        #1;
        total++;
        if (rd_busy_n[0] !== 1'b0) begin bad++; $display("FAIL flush.x8 got=%b exp=0", rd_busy_n[0]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wr_en = NW'($urandom);
            for (int k = 0; k < NW; k++) begin
                wr_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
                wr_data[k*XL +: XL] = $urandom;
            end
            for (int i = 0; i < NR; i++)
                rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
            issue_en = ($urandom_range(0, 2) == 0);
            issue_addr = AW'($urandom_range(0, 7));
            flush = ($urandom_range(0, 15) == 0);
            #2;
            for (int i = 0; i < NR; i++) begin
                total += 4;
                if (rdb(i) !== exp_data(ra(i), 1'b1)) begin bad++; $display("FAIL rand.data_b[%0d] c=%0d got=%h exp=%h", i, c, rdb(i), exp_data(ra(i), 1'b1)); end
                if (rdn(i) !== exp_data(ra(i), 1'b0)) begin bad++; $display("FAIL rand.data_n[%0d] c=%0d got=%h exp=%h", i, c, rdn(i), exp_data(ra(i), 1'b0)); end
                if (rd_busy_b[i] !== exp_busy(ra(i), 1'b1)) begin bad++; $display("FAIL rand.busy_b[%0d] c=%0d got=%b exp=%b", i, c, rd_busy_b[i], exp_busy(ra(i), 1'b1)); end
                if (rd_busy_n[i] !== exp_busy(ra(i), 1'b0)) begin bad++; $display("FAIL rand.busy_n[%0d] c=%0d got=%b exp=%b", i, c, rd_busy_n[i], exp_busy(ra(i), 1'b0)); end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_x0();
        test_conflict();
        test_scoreboard();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_register_file_mp
